// File: rtl/nano_pkg.sv
// Shared definitions for the NanoProcessor fetch path: default widths and FSM state encoding.
package nano_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 8;

  // Two-bit state encoding for the fetch FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_sequencer_counter.sv
// Loadable up-counter used as the program counter; load has priority over count.
module counter #(
  parameter int unsigned N = 4
) (
  input  logic         clock,
  input  logic         areset,
  input  logic         sload,
  input  logic         count_enable,
  input  logic [N-1:0] data,
  output logic [N-1:0] q
);

  logic [N-1:0] r_q;

  // Counter register: async clear, synchronous load or increment (wraps mod 2^N)
  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      r_q <= '0;
    end else if (sload) begin
      r_q <= data;
    end else if (count_enable) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: IDLE->FETCH->EXEC loop against a req/ready memory,
// owning the PC through a loadable counter, with jump, stall, halt/resume and wrap report.
module fetch_sequencer
  import nano_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              areset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              halted,
  output logic              wrap
);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_sload;
  logic              w_count_en;
  logic              w_capture;
  logic [ADDR_W-1:0] w_pc;
  logic [DATA_W-1:0] r_instr;
  logic              r_instr_valid;
  logic              r_wrap;

  // PC lives in the counter; only the FSM's load/increment strobes touch it
  counter #(
    .N(ADDR_W)
  ) u_pc (
    .clock       (clock),
    .areset      (areset),
    .sload       (w_sload),
    .count_enable(w_count_en),
    .data        (jump_target),
    .q           (w_pc)
  );

  // State register
  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and PC strobes; strobes only ever fire in an unstalled EXEC, never both at once
  always_comb begin
    w_state_next = r_state;
    w_sload      = 1'b0;
    w_count_en   = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          w_capture    = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          w_sload      = jump_en;
          w_count_en   = ~jump_en;
          w_state_next = halt_req ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (start) w_state_next = ST_FETCH;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Instruction capture, valid pulse and wrap pulse (wrap only on an increment out of all-ones)
  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_wrap        <= 1'b0;
    end else begin
      if (w_capture) r_instr <= mem_rdata;
      r_instr_valid <= w_capture;
      r_wrap        <= w_count_en & (&w_pc);
    end
  end

  assign mem_req     = (r_state == ST_FETCH);
  assign halted      = (r_state == ST_HALT);
  assign pc          = w_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign wrap        = r_wrap;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer plus a hand-written async-reset sequence.
module tb_fetch_sequencer;

  typedef struct {
    logic       start;
    logic       halt_req;
    logic       stall;
    logic       jump_en;
    logic [3:0] tgt;
    logic       rdy;
    logic [7:0] rdata;
    logic       e_req;
    logic [3:0] e_pc;
    logic [7:0] e_instr;
    logic       e_iv;
    logic       e_halted;
    logic       e_wrap;
  } vec_t;

  localparam int NV = 33;

  logic       clk = 1'b0;
  logic       areset;
  logic       start, halt_req, stall, jump_en, mem_ready;
  logic [3:0] jump_target;
  logic [7:0] mem_rdata;
  logic       mem_req, instr_valid, halted, wrap;
  logic [3:0] pc;
  logic [7:0] instr;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs [NV];

  fetch_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clock      (clk),
    .areset     (areset),
    .start      (start),
    .halt_req   (halt_req),
    .stall      (stall),
    .jump_en    (jump_en),
    .jump_target(jump_target),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_req    (mem_req),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .halted     (halted),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic h, logic st, logic j, logic [3:0] t, logic r,
                              logic [7:0] d, logic eq, logic [3:0] ep, logic [7:0] ei,
                              logic ev, logic eh, logic ew);
    vec_t v;
    v.start = s; v.halt_req = h; v.stall = st; v.jump_en = j; v.tgt = t; v.rdy = r;
    v.rdata = d; v.e_req = eq; v.e_pc = ep; v.e_instr = ei; v.e_iv = ev;
    v.e_halted = eh; v.e_wrap = ew;
    return v;
  endfunction

  task automatic check_out(string name, vec_t v);
    n_tests++;
    if (mem_req !== v.e_req || pc !== v.e_pc || instr !== v.e_instr ||
        instr_valid !== v.e_iv || halted !== v.e_halted || wrap !== v.e_wrap) begin
      n_fail++;
      $display("FAIL %s: got req=%b pc=%h instr=%h iv=%b halted=%b wrap=%b, want req=%b pc=%h instr=%h iv=%b halted=%b wrap=%b",
               name, mem_req, pc, instr, instr_valid, halted, wrap,
               v.e_req, v.e_pc, v.e_instr, v.e_iv, v.e_halted, v.e_wrap);
    end else begin
      $display("[TB] %s: req=%b pc=%h instr=%h iv=%b halted=%b wrap=%b",
               name, mem_req, pc, instr, instr_valid, halted, wrap);
    end
  endtask

  task automatic drive(vec_t v);
    start = v.start; halt_req = v.halt_req; stall = v.stall; jump_en = v.jump_en;
    jump_target = v.tgt; mem_ready = v.rdy; mem_rdata = v.rdata;
  endtask

  // Drive inputs, take one clock edge, check outputs 1 time unit later
  task automatic run_vec(string name, vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check_out(name, v);
  endtask

  initial begin
    // start  halt stall jump tgt  rdy rdata   req pc    instr  iv hlt wrap
    vecs[0]  = mk(0,0,0,0,4'h0,1,8'h77, 0,4'h0,8'h00,0,0,0); // IDLE ignores mem_ready
    vecs[1]  = mk(1,0,0,0,4'h0,0,8'h00, 1,4'h0,8'h00,0,0,0); // start -> FETCH
    vecs[2]  = mk(0,0,0,0,4'h0,1,8'h10, 0,4'h0,8'h10,1,0,0);
    vecs[3]  = mk(0,0,0,0,4'h0,0,8'h00, 1,4'h1,8'h10,0,0,0);
    vecs[4]  = mk(0,0,0,0,4'h0,1,8'h11, 0,4'h1,8'h11,1,0,0);
    vecs[5]  = mk(0,0,0,0,4'h0,0,8'h00, 1,4'h2,8'h11,0,0,0);
    vecs[6]  = mk(0,0,0,0,4'h0,0,8'h00, 1,4'h2,8'h11,0,0,0); // memory wait x3
    vecs[7]  = mk(0,0,0,0,4'h0,0,8'h00, 1,4'h2,8'h11,0,0,0);
    vecs[8]  = mk(0,0,0,0,4'h0,0,8'h00, 1,4'h2,8'h11,0,0,0);
    vecs[9]  = mk(0,0,0,0,4'h0,1,8'h12, 0,4'h2,8'h12,1,0,0); // capture on 4th
    vecs[10] = mk(0,0,0,1,4'hA,0,8'h00, 1,4'hA,8'h12,0,0,0); // jump to A
    vecs[11] = mk(0,0,0,0,4'h0,1,8'h20, 0,4'hA,8'h20,1,0,0);
    vecs[12] = mk(0,1,1,1,4'h5,1,8'h00, 0,4'hA,8'h20,0,0,0); // stalled: nothing acted on
    vecs[13] = mk(0,1,1,1,4'h5,0,8'h00, 0,4'hA,8'h20,0,0,0);
    vecs[14] = mk(0,0,0,1,4'h5,0,8'h00, 1,4'h5,8'h20,0,0,0); // jump after stall
    vecs[15] = mk(0,0,0,0,4'h0,1,8'h21, 0,4'h5,8'h21,1,0,0);
    vecs[16] = mk(0,0,0,1,4'hF,0,8'h00, 1,4'hF,8'h21,0,0,0);
    vecs[17] = mk(0,0,0,0,4'h0,1,8'h22, 0,4'hF,8'h22,1,0,0);
    vecs[18] = mk(0,0,0,0,4'h0,0,8'h00, 1,4'h0,8'h22,0,0,1); // F -> 0 wrap
    vecs[19] = mk(0,0,0,0,4'h0,0,8'h00, 1,4'h0,8'h22,0,0,0); // wrap one cycle only
    vecs[20] = mk(0,0,0,0,4'h0,1,8'h23, 0,4'h0,8'h23,1,0,0);
    vecs[21] = mk(0,0,0,1,4'hF,0,8'h00, 1,4'hF,8'h23,0,0,0);
    vecs[22] = mk(0,0,0,0,4'h0,1,8'h24, 0,4'hF,8'h24,1,0,0);
    vecs[23] = mk(0,0,0,1,4'h0,0,8'h00, 1,4'h0,8'h24,0,0,0); // jump to 0: no wrap
    vecs[24] = mk(0,0,0,0,4'h0,1,8'h25, 0,4'h0,8'h25,1,0,0);
    vecs[25] = mk(0,1,0,1,4'h3,0,8'h00, 0,4'h3,8'h25,0,1,0); // jump + halt
    vecs[26] = mk(0,0,0,1,4'h9,1,8'h99, 0,4'h3,8'h25,0,1,0); // HALT ignores others
    vecs[27] = mk(1,0,0,0,4'h0,0,8'h00, 1,4'h3,8'h25,0,0,0); // resume at 3
    vecs[28] = mk(0,0,0,0,4'h0,1,8'h26, 0,4'h3,8'h26,1,0,0);
    vecs[29] = mk(1,0,0,0,4'h0,0,8'h00, 1,4'h4,8'h26,0,0,0); // start in EXEC ignored
    vecs[30] = mk(0,1,0,0,4'h0,1,8'h27, 0,4'h4,8'h27,1,0,0); // halt_req in FETCH ignored
    vecs[31] = mk(0,1,0,0,4'h0,0,8'h00, 0,4'h5,8'h27,0,1,0); // halt, increment
    vecs[32] = mk(1,0,0,0,4'h0,0,8'h00, 1,4'h5,8'h27,0,0,0); // FETCH at 5

    drive(mk(0,0,0,0,4'h0,0,8'h00, 0,4'h0,8'h00,0,0,0));
    areset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", mk(0,0,0,0,4'h0,0,8'h00, 0,4'h0,8'h00,0,0,0));
    areset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Async reset in the middle of a FETCH cycle: outputs clear before the next edge
    drive(mk(0,0,0,0,4'h0,1,8'h55, 0,4'h0,8'h00,0,0,0));
    #2;
    areset = 1'b0;
    #1;
    check_out("async_reset", mk(0,0,0,0,4'h0,0,8'h00, 0,4'h0,8'h00,0,0,0));
    @(posedge clk);
    #1;
    areset = 1'b1;
    run_vec("late_ready0", mk(0,0,0,0,4'h0,1,8'h55, 0,4'h0,8'h00,0,0,0));
    run_vec("late_ready1", mk(0,0,0,0,4'h0,1,8'h55, 0,4'h0,8'h00,0,0,0));
    run_vec("restart",     mk(1,0,0,0,4'h0,0,8'h00, 1,4'h0,8'h00,0,0,0));
    run_vec("refetch",     mk(0,0,0,0,4'h0,1,8'h30, 0,4'h0,8'h30,1,0,0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
